// File: rtl/ifu_prefetch_q_if.sv
// Fetch-unit bus bundle: instruction-memory request/response side and ID-side instruction handshake.
interface ifu_prefetch_q_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Memory side: a request is accepted on any edge where mem_req_o && mem_gnt_i;
  // responses return in order on mem_rvalid_i and can never be back-pressured.
  // ID side: an instruction transfers on any edge where inst_valid_o && id_ready_i.
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              id_ready_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output inst_valid_o, inst_o, inst_addr_o,
    input  id_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  inst_valid_o, inst_o, inst_addr_o,
    output id_ready_i
  );
endinterface

// File: rtl/ifu_prefetch_q.sv
// Prefetching instruction fetch unit: owns the PC, pipelines memory requests, buffers responses in order.
// Optional macro ALIOTH_IFU_BYPASS_EN adds a zero-latency path from a live response to the ID outputs.
module ifu_prefetch_q #(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000,
  parameter int                PC_STEP         = 4,
  parameter logic [DATA_W-1:0] NOP_INST        = 32'h0000_0013
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 jump_flag_i,
  input  logic [ADDR_W-1:0]                    jump_addr_i,
  input  logic                                 hold_i,
  ifu_prefetch_q_if.master                     bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int AF_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // Stale responses can pile up across back-to-back jumps, so give the drop counter headroom.
  localparam int DROP_W = OUT_W + 3;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_af [MAX_OUTSTANDING];
  logic [AF_W-1:0]   r_af_rd;
  logic [AF_W-1:0]   r_af_wr;
  logic [OUT_W-1:0]  r_live;
  logic [DROP_W-1:0] r_drop;
  logic              r_req_pend;

  logic w_credit;
  logic w_grant;
  logic w_live_rsp;
  logic w_byp_valid;
  logic w_byp_take;
  logic w_push;
  logic w_pop;
  logic w_q_nonempty;

  function automatic logic [AF_W-1:0] af_inc(input logic [AF_W-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + AF_W'(1);
  endfunction

  // A queue slot is reserved at grant, so live responses always find space.
  assign w_credit   = ((32'(r_count) + 32'(r_live)) < DEPTH) && (32'(r_live) < MAX_OUTSTANDING);
  // Once raised, the request ignores hold_i until it is granted; only a jump withdraws it.
  assign bus.mem_req_o  = rst && !jump_flag_i && w_credit && (r_req_pend || !hold_i);
  assign bus.mem_addr_o = r_pc;
  assign w_grant        = bus.mem_req_o && bus.mem_gnt_i;
  assign w_live_rsp     = bus.mem_rvalid_i && (r_drop == '0);
  assign w_q_nonempty   = (r_count != '0);

`ifdef ALIOTH_IFU_BYPASS_EN
  assign w_byp_valid = !w_q_nonempty && w_live_rsp;
  assign w_byp_take  = w_byp_valid && bus.id_ready_i;
`else
  assign w_byp_valid = 1'b0;
  assign w_byp_take  = 1'b0;
`endif

  assign w_push = w_live_rsp && !w_byp_take;
  assign w_pop  = w_q_nonempty && bus.id_ready_i;

  always_comb begin
    bus.inst_valid_o = w_q_nonempty || w_byp_valid;
    bus.inst_o       = NOP_INST;
    bus.inst_addr_o  = '0;
    if (w_q_nonempty) begin
      bus.inst_o      = r_q_data[r_rd_ptr];
      bus.inst_addr_o = r_q_addr[r_rd_ptr];
    end else if (w_byp_valid) begin
      bus.inst_o      = bus.mem_rdata_i;
      bus.inst_addr_o = r_af[r_af_rd];
    end
  end

  assign outstanding_o = r_live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_af_rd    <= '0;
      r_af_wr    <= '0;
      r_live     <= '0;
      r_drop     <= '0;
      r_req_pend <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_addr[i] <= '0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_af[i] <= '0;
      end
    end else if (jump_flag_i) begin
      // Every response still in flight becomes stale; one arriving now is consumed this edge.
      r_pc       <= jump_addr_i;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_af_rd    <= '0;
      r_af_wr    <= '0;
      r_live     <= '0;
      r_drop     <= r_drop + DROP_W'(r_live) - DROP_W'(bus.mem_rvalid_i);
      r_req_pend <= 1'b0;
    end else begin
      if (w_grant) begin
        r_pc           <= r_pc + ADDR_W'(PC_STEP);
        r_af[r_af_wr]  <= r_pc;
        r_af_wr        <= af_inc(r_af_wr);
      end
      if (w_live_rsp) begin
        r_af_rd <= af_inc(r_af_rd);
      end
      if (bus.mem_rvalid_i && (r_drop != '0)) begin
        r_drop <= r_drop - DROP_W'(1);
      end
      if (w_push) begin
        r_q_data[r_wr_ptr] <= bus.mem_rdata_i;
        r_q_addr[r_wr_ptr] <= r_af[r_af_rd];
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_live     <= r_live + OUT_W'(w_grant) - OUT_W'(w_live_rsp);
      r_req_pend <= bus.mem_req_o && !bus.mem_gnt_i;
    end
  end
endmodule

// File: tb/tb_ifu_prefetch_q.sv
// Bench for ifu_prefetch_q: directed phases plus random traffic against a queue-based fetch model.
module tb_ifu_prefetch_q;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DMASK    = 32'hA5A5_0000;
`ifdef ALIOTH_IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              jump_flag_i = 1'b0;
  logic [ADDR_W-1:0] jump_addr_i = '0;
  logic              hold_i = 1'b0;
  logic [1:0]        outstanding_o;

  ifu_prefetch_q_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ifu_prefetch_q #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_i        (hold_i),
    .bus           (bus),
    .outstanding_o (outstanding_o)
  );

  always #5 clk = ~clk;

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_grants = 0;
  int          n_hs = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] live_q[$];
  int          m_drop = 0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    live_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    m_drop = 0;
    m_pc   = RESET_PC;
    m_pend = 1'b0;
  endtask

  // One clock: drive at negedge, check just after, update memory and model at posedge.
  task automatic step(input bit jmp, input logic [31:0] jaddr, input bit hold, input bit gnt,
                      input bit rdy, input int lat);
    bit          rv, credit, exp_req, live_rsp, was_empty, exp_valid, dut_req;
    logic [31:0] exp_addr, dut_addr, a;
    @(negedge clk);
    rv = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
    jump_flag_i      = jmp;
    jump_addr_i      = jaddr;
    hold_i           = hold;
    bus.mem_gnt_i    = gnt;
    bus.id_ready_i   = rdy;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rv ? (mem_addr_q[0] ^ DMASK) : $urandom;
    #1;
    credit    = ((exp_q.size() + live_q.size()) < DEPTH) && (live_q.size() < MAXO);
    exp_req   = !jmp && credit && (m_pend || !hold);
    live_rsp  = rv && (m_drop == 0);
    was_empty = (exp_q.size() == 0);
    exp_valid = !was_empty || (BYP && live_rsp);
    check_eq("mem_req", 32'(bus.mem_req_o), 32'(exp_req));
    if (exp_req) check_eq("mem_addr", bus.mem_addr_o, m_pc);
    check_eq("outstanding", 32'(outstanding_o), 32'(live_q.size()));
    check_eq("inst_valid", 32'(bus.inst_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      if (!was_empty) exp_addr = exp_q[0];
      else if (live_q.size() > 0) exp_addr = live_q[0];
      else exp_addr = 32'hDEAD_BEEF;
      check_eq("inst_addr", bus.inst_addr_o, exp_addr);
      check_eq("inst_data", bus.inst_o, exp_addr ^ DMASK);
    end else begin
      check_eq("idle_inst", bus.inst_o, NOP);
      check_eq("idle_addr", bus.inst_addr_o, 32'h0);
    end
    if (bus.inst_valid_o && rdy && !jmp) n_hs++;
    dut_req  = bus.mem_req_o;
    dut_addr = bus.mem_addr_o;
    @(posedge clk);
    // memory
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (dut_req && gnt) begin
      mem_addr_q.push_back(dut_addr);
      mem_due_q.push_back(cyc + lat);
      n_grants++;
    end
    // reference model
    if (jmp) begin
      m_drop = m_drop + live_q.size() - (rv ? 1 : 0);
      live_q.delete();
      exp_q.delete();
      m_pc   = jaddr;
      m_pend = 1'b0;
    end else begin
      if (!was_empty && rdy) void'(exp_q.pop_front());
      if (rv && m_drop > 0) m_drop--;
      else if (rv && live_q.size() > 0) begin
        a = live_q.pop_front();
        if (!(BYP && was_empty && rdy)) exp_q.push_back(a);
      end
      if (exp_req && gnt) begin
        live_q.push_back(m_pc);
        m_pc   = m_pc + 32'd4;
        m_pend = 1'b0;
      end else begin
        m_pend = exp_req;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(bus.mem_req_o), 32'h0);
    check_eq({tag, "_valid"}, 32'(bus.inst_valid_o), 32'h0);
    check_eq({tag, "_inst"}, bus.inst_o, NOP);
    check_eq({tag, "_addr"}, bus.inst_addr_o, 32'h0);
    check_eq({tag, "_outst"}, 32'(outstanding_o), 32'h0);
  endtask

  initial begin
    int hs0, g0;
    logic [31:0] ja;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.id_ready_i   = 1'b1;
    // reset values with hold low so the request gating by reset is exercised
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    hold_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // streaming: grant every cycle, 1-cycle latency, always ready
    for (int i = 0; i < 20; i++) begin
      if (i == 4) hs0 = n_hs;
      step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1);
    end
    check_eq("throughput", 32'(n_hs - hs0), 32'd16);

    // two requests in flight at 3-cycle latency, then jump to 0x100
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 3);
    step(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 3);

    // hold while responses are in flight
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 2);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 2);

    // PC wrap
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      ja = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF0;
      step($urandom_range(0, 99) < 3, ja, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, $urandom_range(1, 3));
    end

    // reset mid-stream takes effect without a clock edge
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    hold_i           = 1'b1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // ID stalled: exactly DEPTH grants, then drain in order
    g0 = n_grants;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1);
    check_eq("stall_grants", 32'(n_grants - g0), 32'(DEPTH));
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1);

    // final drain with memory idle
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1);
    check_eq("drain_empty", 32'(bus.inst_valid_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
